// File: rtl/timer_prescaler.sv
// Clock-enable prescaler for the timer counter: emits a one-cycle tick every
// 2^(cks+1) cycles while enabled, with glitch-free divide-select changes.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | divider held at zero, no ticks, sel_active follows cks
//  RUN   | divider counting, tick when the selected low bits are all ones
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_en,
    input  logic       restart,
    input  logic [1:0] cks,
    output logic       clk_ena,
    output logic [1:0] sel_active,
    output logic       running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] div_q;
    logic [1:0] sel_q;
    logic       ena_q;
    logic       run_q;

    logic [3:0] mask_d;
    logic       tick_due_d;
    logic [3:0] div_inc_d;

    always_comb begin
        mask_d = 4'b0001;
        case (sel_q)
            2'd0:    mask_d = 4'b0001;
            2'd1:    mask_d = 4'b0011;
            2'd2:    mask_d = 4'b0111;
            default: mask_d = 4'b1111;
        endcase
    end

    assign tick_due_d = ((div_q & mask_d) == mask_d);

    // A select change restarts the divider so the new period is always whole,
    // even when switching to a slower rate with stale upper divider bits.
    assign div_inc_d = (tick_due_d && (cks != sel_q)) ? 4'd0 : div_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 4'd0;
            sel_q   <= 2'd0;
            ena_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_q <= 4'd0;
                    ena_q <= 1'b0;
                    sel_q <= cks;
                    if (pre_en) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end else begin
                        run_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (!pre_en) begin
                        state_q <= IDLE;
                        run_q   <= 1'b0;
                        div_q   <= 4'd0;
                        ena_q   <= 1'b0;
                        sel_q   <= cks;
                    end else if (restart) begin
                        run_q   <= 1'b1;
                        div_q   <= 4'd0;
                        ena_q   <= 1'b0;
                        sel_q   <= cks;
                    end else begin
                        run_q   <= 1'b1;
                        div_q   <= div_inc_d;
                        ena_q   <= tick_due_d;
                        if (tick_due_d) begin
                            sel_q <= cks;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= 1'b0;
                    div_q   <= 4'd0;
                    ena_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clk_ena    = ena_q;
    assign sel_active = sel_q;
    assign running    = run_q;

endmodule

// File: tb/tb_timer_prescaler.sv
// Self-checking bench for timer_prescaler: vector table for reset/priority
// cases plus sequences for divide sweep, select change, restart and counter use.
module tb_timer_prescaler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pre_en = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] cks = 2'd0;
    logic       clk_ena;
    logic [1:0] sel_active;
    logic       running;

    timer_prescaler dut (
        .clk        (clk),
        .rst        (rst),
        .pre_en     (pre_en),
        .restart    (restart),
        .cks        (cks),
        .clk_ena    (clk_ena),
        .sel_active (sel_active),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       p;
        logic       rs;
        logic [1:0] c;
        logic       e_ena;
        logic       e_run;
        logic [1:0] e_sel;
    } vec_t;

    typedef struct {
        logic       ena;
        logic       run;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input logic r, input logic p, input logic rs, input logic [1:0] c,
                        input logic e_ena, input logic e_run, input logic [1:0] e_sel,
                        input string nm);
        exp_t e;
        rst = r;
        pre_en = p;
        restart = rs;
        cks = c;
        exp_q.push_back('{e_ena, e_run, e_sel});
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (clk_ena !== e.ena || running !== e.run || sel_active !== e.sel) begin
                errors++;
                $display("FAIL %s: got ena=%b run=%b sel=%0d expected ena=%b run=%b sel=%0d",
                         nm, clk_ena, running, sel_active, e.ena, e.run, e.sel);
            end
        end
    endtask

    vec_t vt[20];
    int   ticks;
    int   per;
    logic [7:0] cnt;
    logic       ovf;
    int   ovf_tick;
    int   ovf_cycle;

    initial begin
        vt[0]  = '{1, 1, 0, 2'd3, 0, 0, 2'd0};
        vt[1]  = '{1, 1, 0, 2'd3, 0, 0, 2'd0};
        vt[2]  = '{1, 1, 0, 2'd3, 0, 0, 2'd0};
        vt[3]  = '{1, 1, 0, 2'd3, 0, 0, 2'd0};
        vt[4]  = '{1, 1, 0, 2'd3, 0, 0, 2'd0};
        vt[5]  = '{0, 1, 0, 2'd3, 0, 1, 2'd3};
        vt[6]  = '{0, 1, 0, 2'd3, 0, 1, 2'd3};
        vt[7]  = '{1, 1, 0, 2'd3, 0, 0, 2'd0};
        vt[8]  = '{0, 0, 0, 2'd2, 0, 0, 2'd2};
        vt[9]  = '{0, 0, 1, 2'd1, 0, 0, 2'd1};
        vt[10] = '{0, 1, 0, 2'd0, 0, 1, 2'd0};
        vt[11] = '{0, 1, 0, 2'd0, 0, 1, 2'd0};
        vt[12] = '{0, 1, 0, 2'd0, 1, 1, 2'd0};
        vt[13] = '{0, 1, 0, 2'd0, 0, 1, 2'd0};
        vt[14] = '{0, 0, 0, 2'd0, 0, 0, 2'd0};
        vt[15] = '{0, 0, 0, 2'd3, 0, 0, 2'd3};
        vt[16] = '{0, 1, 0, 2'd2, 0, 1, 2'd2};
        vt[17] = '{0, 1, 1, 2'd1, 0, 1, 2'd1};
        vt[18] = '{0, 0, 1, 2'd1, 0, 0, 2'd1};
        vt[19] = '{0, 0, 0, 2'd1, 0, 0, 2'd1};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            step(vt[i].r, vt[i].p, vt[i].rs, vt[i].c,
                 vt[i].e_ena, vt[i].e_run, vt[i].e_sel, $sformatf("vec%0d", i));
        end

        // Divide sweep: first tick at edge P after entry, then every P cycles.
        for (int k = 0; k < 4; k++) begin
            per = 2 << k;
            step(0, 0, 0, 2'(k), 0, 0, 2'(k), "sweep_idle");
            ticks = 0;
            for (int n = 0; n < 64; n++) begin
                step(0, 1, 0, 2'(k), (n > 0) && (n % per == 0), 1, 2'(k),
                     $sformatf("sweep_k%0d_n%0d", k, n));
                if (clk_ena === 1'b1) ticks++;
            end
            check_int($sformatf("sweep_count_k%0d", k), ticks, 63 / per);
        end

        // Disable before the first tick.
        step(0, 0, 0, 2'd0, 0, 0, 2'd0, "dis_idle");
        step(0, 1, 0, 2'd0, 0, 1, 2'd0, "dis_entry");
        for (int n = 0; n < 8; n++) begin
            step(0, 0, 0, 2'd0, 0, 0, 2'd0, $sformatf("dis_n%0d", n));
        end

        // Select change mid-period takes effect only on the tick edge.
        step(0, 0, 0, 2'd3, 0, 0, 2'd3, "chg_idle");
        for (int n = 0; n < 24; n++) begin
            step(0, 1, 0, (n >= 5) ? 2'd0 : 2'd3,
                 (n == 16) || (n > 16 && n % 2 == 0), 1,
                 (n >= 16) ? 2'd0 : 2'd3, $sformatf("chg_n%0d", n));
        end

        // Restart on the cycle a tick is due.
        step(0, 0, 0, 2'd1, 0, 0, 2'd1, "rst_idle");
        for (int n = 0; n < 18; n++) begin
            step(0, 1, (n == 8), 2'd1,
                 (n == 4) || (n >= 12 && (n - 8) % 4 == 0), 1, 2'd1,
                 $sformatf("rsc_n%0d", n));
        end

        // Downstream 8-bit up counter loaded with 0, clocked by clk_ena at /2.
        step(0, 0, 0, 2'd0, 0, 0, 2'd0, "cnt_idle");
        cnt = 8'd0;
        ovf = 1'b0;
        ticks = 0;
        ovf_tick = -1;
        ovf_cycle = -1;
        for (int n = 0; n < 520; n++) begin
            step(0, 1, 0, 2'd0, (n > 0) && (n % 2 == 0), 1, 2'd0,
                 $sformatf("cnt_n%0d", n));
            if (clk_ena === 1'b1) begin
                ticks++;
                {ovf, cnt} = {1'b0, cnt} + 9'd1;
                if (ovf && ovf_tick < 0) begin
                    ovf_tick = ticks;
                    ovf_cycle = n;
                end
            end
        end
        check_int("ovf_tick", ovf_tick, 256);
        check_int("ovf_cycle", ovf_cycle, 512);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_prescaler.md
TIMER_PRESCALER -- requirements
Module: timer_prescaler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port pre_en, input, 1 bit: prescaler run enable; 1 = run, 0 = idle.
REQ-004 SHALL have port restart, input, 1 bit: one-cycle request to clear the divider and reload the divide select.
REQ-005 SHALL have port cks, input, 2 bits: divide select; 0 = /2, 1 = /4, 2 = /8, 3 = /16.
REQ-006 SHALL have port clk_ena, output, 1 bit: registered one-cycle tick consumed by the timer counter's clk_ena input.
REQ-007 SHALL have port sel_active, output, 2 bits: divide select currently in effect.
REQ-008 SHALL have port running, output, 1 bit: 1 while in state RUN.

Function
REQ-009 SHALL implement a two-state FSM: IDLE, RUN.
REQ-010 SHALL contain a 4-bit divider div_q; in RUN it increments by 1 each cycle and wraps 15 -> 0.
REQ-011 SHALL, in IDLE with pre_en=1, move to RUN at the next edge, with div_q=0 and sel_active=cks.
REQ-012 SHALL, in RUN with pre_en=0, move to IDLE at the next edge, with div_q=0 and clk_ena=0; a tick due that cycle is suppressed.
REQ-013 SHALL, in IDLE, hold div_q=0 and clk_ena=0, and track cks into sel_active every cycle.
REQ-014 SHALL, with k=sel_active, set clk_ena=1 at the next edge iff state=RUN, restart=0, pre_en=1, and div_q[k:0] all ones; otherwise clk_ena=0.
REQ-015 SHALL produce the first tick 2^(k+1) edges after entry to RUN, then exactly one tick every 2^(k+1) cycles, each tick 1 cycle wide.
REQ-016 SHALL apply a cks change made in RUN only at the edge on which clk_ena is set to 1 (sel_active<=cks), so no tick period is truncated or stretched mid-period.
REQ-017 SHALL, on restart=1 in RUN (pre_en=1): set div_q=0 and sel_active=cks, suppress any tick due that cycle, and stay in RUN; restart in IDLE has no effect.
REQ-018 SHALL give priority rst > pre_en=0 > restart > normal counting when events coincide.
REQ-019 SHALL keep running = (state == RUN), registered.

Reset
REQ-020 SHALL, on rst=1 at an edge, force state=IDLE, div_q=0, clk_ena=0, running=0, sel_active=0, regardless of all other inputs, including mid-period in RUN.
REQ-021 SHALL, after rst deasserts, follow REQ-011 without any extra latency.

Verification
REQ-022 Reset: rst=1 for 5 cycles with pre_en=1, cks=3 -> clk_ena=0, running=0, sel_active=0 throughout; after release, IDLE->RUN at the next edge.
REQ-023 Divide sweep: for each cks 0..3, pre_en=1 for 64 cycles -> first tick at edge 2/4/8/16 after RUN entry, period 2/4/8/16, width 1, count 32/16/8/4 (+/-1 at window edge).
REQ-024 Disable before first tick: cks=0, pre_en=1 for 1 cycle then 0 -> no clk_ena pulse ever; running returns to 0; div_q=0.
REQ-025 Mid-period select change: cks=3 running, change to cks=0 at edge 5 -> next tick still at edge 16, subsequent ticks every 2 cycles, sel_active switches on the tick edge.
REQ-026 Restart collision: cks=1, restart=1 on the cycle a tick is due -> no tick that cycle; next tick 4 edges later.
REQ-027 Downstream integration: drive counter (start_counter=0, up_down=1, load) with clk_ena at /2 -> overflow asserts after exactly 256 ticks, not earlier.
